ula_sequencer: RTL

Issue/writeback controller on the driving side of the 8-bit ULA in each core of the multiprocessor architecture. Accepts one instruction at a time over a valid/ready handshake, reads operands from an internal 8x8 register file, drives `ula_operation`/`operand1`/`operand2` to the ULA, and samples its `result`/`flags`. Writes the result back to the register file and holds a flags register. Rejects invalid opcodes and divide/modulo by zero without writing back.

---
 rtl/ula_pkg.sv | 44 ++++
 rtl/ula_regfile.sv | 38 +++
 rtl/ula_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared opcode map, FSM state encoding and flag bit positions for the
// ULA issue/writeback sequencer.
package ula_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0011;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0100;
  localparam logic [OP_W-1:0] OP_MOD  = 4'b0101;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0110;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1000;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
  localparam logic [OP_W-1:0] OP_XNOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OPERAND   = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_P = 3;
  localparam int FLAG_V = 6;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XNOR);
  endfunction

  // DIV and MOD are the only operations that reject a zero operand2.
  function automatic logic needs_nonzero_op2(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// Register file for the sequencer: two operand read ports, a debug read port
// and one synchronous write port. r0 is hardwired to zero.
module ula_regfile
  import ula_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/ula_sequencer.sv
// Single-issue controller driving the external 8-bit ULA: fetches operands,
// presents them for one EXECUTE cycle, then writes back result and flags.
module ula_sequencer
  import ula_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [7:0]        instr_imm,
  input  logic              instr_use_imm,
  output logic [3:0]        ula_operation,
  output logic [7:0]        operand1,
  output logic [7:0]        operand2,
  input  logic [7:0]        ula_result,
  input  logic [7:0]        ula_flags,
  output logic              done_valid,
  output logic              done_err,
  output logic [REG_AW-1:0] wb_rd,
  output logic [7:0]        wb_data,
  output logic [7:0]        flags_q,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  state_t            state_q;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [DATA_W-1:0] imm_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] operand1_q;
  logic [DATA_W-1:0] operand2_q;
  logic              err_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] ula_flags_q;
  logic [DATA_W-1:0] flags_reg;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] op2_sel;
  logic              err_next;
  logic              rf_we;

  ula_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (rs1_q),
    .rd_data1 (rs1_data),
    .rd_addr2 (rs2_q),
    .rd_data2 (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wr_addr  (rd_q),
    .wr_data  (result_q)
  );

  assign op2_sel  = use_imm_q ? imm_q : rs2_data;
  assign err_next = !is_valid_op(op_q) || (needs_nonzero_op2(op_q) && (op2_sel == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      operand1_q  <= '0;
      operand2_q  <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      ula_flags_q <= '0;
      flags_reg   <= '0;
    end else begin
      case (state_q)
        // Accept: capture the whole instruction, upstream need not hold it.
        ST_IDLE: begin
          if (instr_valid) begin
            op_q      <= instr_op;
            rd_q      <= instr_rd;
            rs1_q     <= instr_rs1;
            rs2_q     <= instr_rs2;
            imm_q     <= instr_imm;
            use_imm_q <= instr_use_imm;
            state_q   <= ST_OPERAND;
          end
        end
        // Operand fetch: register operands so the ULA sees stable inputs.
        ST_OPERAND: begin
          operand1_q <= rs1_data;
          operand2_q <= op2_sel;
          err_q      <= err_next;
          state_q    <= ST_EXECUTE;
        end
        // Execute: the ULA output is captured at the end of this cycle.
        ST_EXECUTE: begin
          result_q    <= ula_result;
          ula_flags_q <= ula_flags;
          state_q     <= ST_WRITEBACK;
        end
        // Writeback: commit result (via regfile port) and flags unless rejected.
        ST_WRITEBACK: begin
          if (!err_q) begin
            flags_reg <= ula_flags_q;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rf_we         = (state_q == ST_WRITEBACK) && !err_q;
  assign instr_ready   = (state_q == ST_IDLE);
  assign ula_operation = (state_q == ST_EXECUTE) ? op_q : OP_NOP;
  assign operand1      = operand1_q;
  assign operand2      = operand2_q;
  assign done_valid    = (state_q == ST_WRITEBACK);
  assign done_err      = (state_q == ST_WRITEBACK) && err_q;
  assign wb_rd         = rd_q;
  assign wb_data       = err_q ? '0 : result_q;
  assign flags_q       = flags_reg;

endmodule
